// File: rtl/fios_casc_3a_sched.sv
`default_nettype none
// fios_casc_3a_sched: control sequencer for a chain of PE_CASC_3A Montgomery PEs,
// producing PE0 controls from the FSM and a per-PE one-cycle skew line.
module fios_casc_3a_sched #(
  parameter int S     = 8,
  parameter int N_PE  = 4,
  parameter int ABREG = 1,
  parameter int MREG  = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [$clog2(S)-1:0]  a_idx_o,
  output logic [$clog2(S)-1:0]  bp_idx_o,
  output logic [N_PE-1:0]       a_reg_en_o,
  output logic [N_PE-1:0]       m_reg_en_o,
  output logic [2*N_PE-1:0]     mux_A_sel_o,
  output logic [2*N_PE-1:0]     mux_B_sel_o,
  output logic [2*N_PE-1:0]     mux_C_sel_o,
  output logic [N_PE-1:0]       CREG_en_o,
  output logic [N_PE-1:0]       RES_delay_en_o,
  output logic [7*N_PE-1:0]     OPMODE_o
);

  localparam int L         = 1 + ABREG + MREG;
  localparam int IW        = $clog2(S);
  localparam int DRAIN_LEN = L + N_PE - 1;
  localparam int WW        = $clog2(DRAIN_LEN + 1);
  localparam int CW        = 17;

  localparam logic [IW-1:0] S_LAST      = IW'(S - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(L - 1);
  localparam logic [WW-1:0] DRAIN_LAST  = WW'(DRAIN_LEN - 1);

  localparam logic [6:0] OP_M   = 7'h05;
  localparam logic [6:0] OP_CM  = 7'h35;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] MULB  = 3'd2;
  localparam logic [2:0] RED   = 3'd3;
  localparam logic [2:0] WAITM = 3'd4;
  localparam logic [2:0] MULP  = 3'd5;
  localparam logic [2:0] DRAIN = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  logic [2:0]    state, state_nxt;
  logic [IW-1:0] i_cnt, j_cnt;
  logic [WW-1:0] w_cnt;

  logic          a_en, m_en, creg_en, res_en;
  logic [1:0]    mux_a, mux_b, mux_c;
  logic [6:0]    opmode;
  logic [CW-1:0] ctl [N_PE];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // i, j and w only wrap under FSM control, never by modulo overflow
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      i_cnt <= '0;
      j_cnt <= '0;
      w_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          i_cnt <= '0;
          j_cnt <= '0;
          w_cnt <= '0;
        end
        MULB:  j_cnt <= (j_cnt == S_LAST) ? '0 : j_cnt + 1'b1;
        WAITM: w_cnt <= (w_cnt == WAIT_LAST) ? '0 : w_cnt + 1'b1;
        MULP: begin
          if (j_cnt == S_LAST) begin
            j_cnt <= '0;
            if (i_cnt != S_LAST) i_cnt <= i_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        DRAIN: w_cnt <= (w_cnt == DRAIN_LAST) ? '0 : w_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = LOAD;
      LOAD:  state_nxt = MULB;
      MULB:  if (j_cnt == S_LAST) state_nxt = RED;
      RED:   state_nxt = WAITM;
      WAITM: if (w_cnt == WAIT_LAST) state_nxt = MULP;
      MULP:  if (j_cnt == S_LAST) state_nxt = (i_cnt == S_LAST) ? DRAIN : LOAD;
      DRAIN: if (w_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_en     = 1'b0;
    m_en     = 1'b0;
    creg_en  = 1'b0;
    res_en   = 1'b0;
    mux_a    = 2'd0;
    mux_b    = 2'd0;
    mux_c    = 2'd0;
    opmode   = 7'h00;
    a_idx_o  = '0;
    bp_idx_o = '0;
    busy_o   = (state != IDLE);
    done_o   = (state == DONE);
    case (state)
      LOAD: begin
        a_en    = 1'b1;
        a_idx_o = i_cnt;
      end
      MULB: begin
        bp_idx_o = j_cnt;
        mux_c    = 2'd1;
        creg_en  = 1'b1;
        res_en   = 1'b1;
        // first iteration has no accumulated C to add
        opmode   = (i_cnt == '0) ? OP_M : OP_CM;
      end
      RED: begin
        mux_a  = 2'd1;
        mux_b  = 2'd1;
        opmode = OP_M;
      end
      WAITM: begin
        opmode = OP_CM;
        m_en   = (w_cnt == WAIT_LAST);
      end
      MULP: begin
        mux_a    = 2'd2;
        mux_b    = 2'd2;
        bp_idx_o = j_cnt;
        mux_c    = 2'd1;
        creg_en  = 1'b1;
        res_en   = 1'b1;
        opmode   = OP_CM;
      end
      default: ;
    endcase
  end

  assign ctl[0] = {a_en, m_en, mux_a, mux_b, mux_c, creg_en, res_en, opmode};

  generate
    for (genvar k = 1; k < N_PE; k++) begin : g_skew
      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) ctl[k] <= '0;
        else         ctl[k] <= ctl[k-1];
      end
    end

    for (genvar k = 0; k < N_PE; k++) begin : g_pe
      assign {a_reg_en_o[k], m_reg_en_o[k], mux_A_sel_o[2*k+:2], mux_B_sel_o[2*k+:2],
              mux_C_sel_o[2*k+:2], CREG_en_o[k], RES_delay_en_o[k], OPMODE_o[7*k+:7]} = ctl[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fios_casc_3a_sched.sv
`default_nettype none
// tb_fios_casc_3a_sched: scoreboard bench; expected per-cycle outputs come from a
// schedule-level model of one full multiplication run.
module tb_fios_casc_3a_sched;

  localparam int S     = 4;
  localparam int N_PE  = 4;
  localparam int ABREG = 1;
  localparam int MREG  = 1;
  localparam int L     = 1 + ABREG + MREG;
  localparam int IW    = $clog2(S);
  localparam int T     = 2*S + L + 2;
  localparam int LAT   = S*T + L + N_PE;

  typedef logic [16:0] ctl_t;
  typedef struct packed {
    logic          busy;
    logic          done;
    logic [IW-1:0] a_idx;
    logic [IW-1:0] bp_idx;
    ctl_t          ctl;
  } rec_t;

  logic clk, rst, start;
  logic busy_o, done_o;
  logic [IW-1:0] a_idx_o, bp_idx_o;
  logic [N_PE-1:0] a_reg_en_o, m_reg_en_o, CREG_en_o, RES_delay_en_o;
  logic [2*N_PE-1:0] mux_A_sel_o, mux_B_sel_o, mux_C_sel_o;
  logic [7*N_PE-1:0] OPMODE_o;

  fios_casc_3a_sched #(.S(S), .N_PE(N_PE), .ABREG(ABREG), .MREG(MREG)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start),
    .busy_o(busy_o), .done_o(done_o), .a_idx_o(a_idx_o), .bp_idx_o(bp_idx_o),
    .a_reg_en_o(a_reg_en_o), .m_reg_en_o(m_reg_en_o),
    .mux_A_sel_o(mux_A_sel_o), .mux_B_sel_o(mux_B_sel_o), .mux_C_sel_o(mux_C_sel_o),
    .CREG_en_o(CREG_en_o), .RES_delay_en_o(RES_delay_en_o), .OPMODE_o(OPMODE_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rec_t exp_q[$];
  ctl_t hist [N_PE];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  bit   model_idle = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h want %0h", name, cyc, got, want);
    end
  endtask

  function automatic ctl_t mk(input logic a, input logic m, input logic [1:0] ma,
                              input logic [1:0] mb, input logic [1:0] mc,
                              input logic cr, input logic rd, input logic [6:0] op);
    return {a, m, ma, mb, mc, cr, rd, op};
  endfunction

  // One full run: S iterations of LOAD/MULB/RED/WAITM/MULP, then drain and done
  task automatic push_run();
    rec_t r;
    for (int i = 0; i < S; i++) begin
      r = '{busy: 1'b1, done: 1'b0, a_idx: IW'(i), bp_idx: '0, ctl: mk(1,0,0,0,0,0,0,7'h00)};
      exp_q.push_back(r);
      for (int j = 0; j < S; j++) begin
        r = '{busy: 1'b1, done: 1'b0, a_idx: '0, bp_idx: IW'(j),
              ctl: mk(0,0,0,0,1,1,1,(i == 0) ? 7'h05 : 7'h35)};
        exp_q.push_back(r);
      end
      r = '{busy: 1'b1, done: 1'b0, a_idx: '0, bp_idx: '0, ctl: mk(0,0,1,1,0,0,0,7'h05)};
      exp_q.push_back(r);
      for (int w = 0; w < L; w++) begin
        r = '{busy: 1'b1, done: 1'b0, a_idx: '0, bp_idx: '0,
              ctl: mk(0,(w == L-1),0,0,0,0,0,7'h35)};
        exp_q.push_back(r);
      end
      for (int j = 0; j < S; j++) begin
        r = '{busy: 1'b1, done: 1'b0, a_idx: '0, bp_idx: IW'(j), ctl: mk(0,0,2,2,1,1,1,7'h35)};
        exp_q.push_back(r);
      end
    end
    for (int d = 0; d < L + N_PE - 1; d++) begin
      r = '{busy: 1'b1, done: 1'b0, a_idx: '0, bp_idx: '0, ctl: '0};
      exp_q.push_back(r);
    end
    r = '{busy: 1'b1, done: 1'b1, a_idx: '0, bp_idx: '0, ctl: '0};
    exp_q.push_back(r);
  endtask

  // Monitor: one expected record per cycle; an empty queue means the model is idle
  always @(negedge clk) begin
    rec_t e;
    ctl_t got;
    cyc++;
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < N_PE; k++) hist[k] = '0;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      model_idle = 1'b0;
    end else begin
      e = '0;
      model_idle = 1'b1;
    end
    for (int k = N_PE-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = e.ctl;
    check("busy",   32'(busy_o),   32'(e.busy));
    check("done",   32'(done_o),   32'(e.done));
    check("a_idx",  32'(a_idx_o),  32'(e.a_idx));
    check("bp_idx", 32'(bp_idx_o), 32'(e.bp_idx));
    for (int k = 0; k < N_PE; k++) begin
      got = {a_reg_en_o[k], m_reg_en_o[k], mux_A_sel_o[2*k+:2], mux_B_sel_o[2*k+:2],
             mux_C_sel_o[2*k+:2], CREG_en_o[k], RES_delay_en_o[k], OPMODE_o[7*k+:7]};
      check($sformatf("pe%0d_ctl", k), 32'(got), 32'(hist[k]));
    end
    if (done_o === 1'b1) begin
      check("done_latency", 32'(cyc - accept_cyc), 32'(LAT));
      check("skew_flushed_at_done",
            32'(|{a_reg_en_o, m_reg_en_o, mux_A_sel_o, mux_B_sel_o, mux_C_sel_o,
                  CREG_en_o, RES_delay_en_o, OPMODE_o}), 32'd0);
    end
  end

  task automatic step(input logic st);
    @(posedge clk);
    if (start && model_idle && !rst) begin
      accept_cyc = cyc;
      push_run();
    end
    #1 start = st;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'(|{busy_o, done_o, a_idx_o, bp_idx_o, a_reg_en_o, m_reg_en_o,
                      mux_A_sel_o, mux_B_sel_o, mux_C_sel_o, CREG_en_o,
                      RES_delay_en_o, OPMODE_o}), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #2 check_all_zero("reset_outputs");
    repeat (3) step(1'b0);
    @(posedge clk);
    #3 rst = 1'b0;

    // single start pulse, full run
    step(1'b1);
    repeat (LAT + 10) step(1'b0);

    // start held high: back-to-back runs, including through DONE
    repeat (2*LAT + 20) step(1'b1);
    repeat (LAT + 5) step(1'b0);

    // random start pulses; pulses while busy must be ignored
    repeat (400) step($urandom_range(0, 7) == 0);
    repeat (LAT + 5) step(1'b0);

    // async reset during MULP of iteration i=2
    step(1'b1);
    step(1'b0);
    repeat (T*2 + 1 + S + 1 + L) step(1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset_midop");
    repeat (3) step(1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    step(1'b1);
    repeat (LAT + 10) step(1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
